// File: rtl/uart_fifo.sv
// Buffered UART: TX/RX FIFOs with valid/ready handshakes, configurable baud,
// data width and parity, plus framing/parity/overrun error pulses.

module uart_fifo_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       full,
    output logic                       empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    // A write into a full buffer is still accepted when the head leaves in the same cycle.
    assign do_wr   = wr_en && (!full || rd_en);
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Pointers wrap modulo DEPTH; level tells full from empty.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_wr && !do_rd)      level <= level + LVL_W'(1);
            else if (!do_wr && do_rd) level <= level - LVL_W'(1);
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clock) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end
endmodule

module uart_fifo #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int BAUD      = 2_000_000,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int TX_DEPTH  = 16,
    parameter int RX_DEPTH  = 16
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          UART_RX,
    output logic                          UART_TX,
    input  logic                          tx_valid,
    input  logic [DATA_BITS-1:0]          tx_data,
    output logic                          tx_ready,
    output logic                          rx_valid,
    output logic [DATA_BITS-1:0]          rx_data,
    input  logic                          rx_ready,
    output logic [$clog2(TX_DEPTH+1)-1:0] tx_level,
    output logic [$clog2(RX_DEPTH+1)-1:0] rx_level,
    output logic                          rx_parity_err,
    output logic                          rx_frame_err,
    output logic                          rx_overrun
);
    localparam int DIV   = CLK_HZ / BAUD;
    localparam int CNT_W = $clog2(DIV);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV / 2 - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK} rx_state_t;

    // Parity bit for a word: even = XOR of data, odd = its inverse.
    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return (^d) ^ (PARITY == 1);
    endfunction

    // ---------------- TX path ----------------
    tx_state_t              tx_state, tx_state_n;
    logic [CNT_W-1:0]       tx_cnt, tx_cnt_n;
    logic [BIT_W-1:0]       tx_bit, tx_bit_n;
    logic [DATA_BITS-1:0]   tx_shift, tx_shift_nx, tx_head;
    logic                   tx_par, tx_par_nx, tx_line_n;
    logic                   tx_load, tx_shift_en, tx_full, tx_empty;

    assign tx_ready = !tx_full;

    uart_fifo_buf #(.WIDTH(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clock(clock), .reset_n(reset_n),
        .wr_en(tx_valid && tx_ready), .wr_data(tx_data),
        .rd_en(tx_load), .rd_data(tx_head),
        .level(tx_level), .full(tx_full), .empty(tx_empty)
    );

    // TX next state: each bit holds for DIV clocks; a waiting byte starts right after STOP.
    always_comb begin
        tx_state_n  = tx_state;
        tx_cnt_n    = tx_cnt + CNT_W'(1);
        tx_bit_n    = tx_bit;
        tx_load     = 1'b0;
        tx_shift_en = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_n = '0;
                if (!tx_empty) begin
                    tx_load    = 1'b1;
                    tx_state_n = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_bit_n   = '0;
                    tx_state_n = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n    = '0;
                    tx_shift_en = 1'b1;
                    if (tx_bit == DATA_LAST) begin
                        if (PARITY != 0) tx_state_n = TX_PARITY;
                        else             tx_state_n = TX_STOP;
                    end else begin
                        tx_bit_n = tx_bit + BIT_W'(1);
                    end
                end
            end
            TX_PARITY: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_state_n = TX_STOP;
                end
            end
            TX_STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n = '0;
                    if (!tx_empty) begin
                        tx_load    = 1'b1;
                        tx_state_n = TX_START;
                    end else begin
                        tx_state_n = TX_IDLE;
                    end
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase

        tx_shift_nx = tx_load ? tx_head : (tx_shift_en ? (tx_shift >> 1) : tx_shift);
        tx_par_nx   = tx_load ? parity_of(tx_head) : tx_par;
        case (tx_state_n)
            TX_START:  tx_line_n = 1'b0;
            TX_DATA:   tx_line_n = tx_shift_nx[0];
            TX_PARITY: tx_line_n = tx_par_nx;
            default:   tx_line_n = 1'b1;
        endcase
    end

    // TX control state; the line is registered so it changes exactly on bit boundaries.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            UART_TX  <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            UART_TX  <= tx_line_n;
        end
    end

    // TX shift register and parity bit (data only).
    always_ff @(posedge clock) begin
        tx_shift <= tx_shift_nx;
        tx_par   <= tx_par_nx;
    end

    // ---------------- RX path ----------------
    rx_state_t              rx_state, rx_state_n;
    logic [CNT_W-1:0]       rx_cnt, rx_cnt_n;
    logic [BIT_W-1:0]       rx_bit, rx_bit_n;
    logic [DATA_BITS-1:0]   rx_shift;
    logic                   rx_par, rx_shift_en, rx_par_en, rx_done, rx_par_ok;
    logic                   rx_sync_p0, rx_sync_p1, rx_sync_p2;
    logic                   rx_wr_vld, rx_full, rx_empty, rx_pop;

    assign rx_valid  = !rx_empty;
    assign rx_pop    = rx_valid && rx_ready;
    assign rx_par_ok = (PARITY == 0) || (rx_par == parity_of(rx_shift));

    uart_fifo_buf #(.WIDTH(DATA_BITS), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clock(clock), .reset_n(reset_n),
        .wr_en(rx_wr_vld), .wr_data(rx_shift),
        .rd_en(rx_pop), .rd_data(rx_data),
        .level(rx_level), .full(rx_full), .empty(rx_empty)
    );

    // Synchroniser: p0/p1 resolve metastability, p2 keeps the previous value for edge detect.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_sync_p0 <= 1'b1;
            rx_sync_p1 <= 1'b1;
            rx_sync_p2 <= 1'b1;
        end else begin
            rx_sync_p0 <= UART_RX;
            rx_sync_p1 <= rx_sync_p0;
            rx_sync_p2 <= rx_sync_p1;
        end
    end

    // RX next state: sample start at DIV/2, then every bit at its midpoint.
    always_comb begin
        rx_state_n  = rx_state;
        rx_cnt_n    = rx_cnt + CNT_W'(1);
        rx_bit_n    = rx_bit;
        rx_shift_en = 1'b0;
        rx_par_en   = 1'b0;
        rx_done     = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_n = '0;
                if (rx_sync_p2 && !rx_sync_p1) rx_state_n = RX_START;
            end
            RX_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_n = '0;
                    rx_bit_n = '0;
                    // A start bit that is high again by its midpoint is a glitch.
                    if (rx_sync_p1) rx_state_n = RX_IDLE;
                    else            rx_state_n = RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n    = '0;
                    rx_shift_en = 1'b1;
                    if (rx_bit == DATA_LAST) begin
                        if (PARITY != 0) rx_state_n = RX_PARITY;
                        else             rx_state_n = RX_STOP;
                    end else begin
                        rx_bit_n = rx_bit + BIT_W'(1);
                    end
                end
            end
            RX_PARITY: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n   = '0;
                    rx_par_en  = 1'b1;
                    rx_state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n = '0;
                    rx_done  = 1'b1;
                    // A low stop bit may be a break: wait for the line to go high.
                    if (rx_sync_p1) rx_state_n = RX_IDLE;
                    else            rx_state_n = RX_BREAK;
                end
            end
            RX_BREAK: begin
                rx_cnt_n = '0;
                if (rx_sync_p1) rx_state_n = RX_IDLE;
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    // RX control state and the one-cycle result pulses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_state      <= RX_IDLE;
            rx_cnt        <= '0;
            rx_bit        <= '0;
            rx_wr_vld     <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            rx_state      <= rx_state_n;
            rx_cnt        <= rx_cnt_n;
            rx_bit        <= rx_bit_n;
            rx_wr_vld     <= rx_done && rx_sync_p1 && rx_par_ok;
            rx_parity_err <= rx_done && !rx_par_ok;
            rx_frame_err  <= rx_done && !rx_sync_p1;
            rx_overrun    <= rx_wr_vld && rx_full && !rx_pop;
        end
    end

    // RX data capture, LSB first (data only).
    always_ff @(posedge clock) begin
        if (rx_shift_en) rx_shift <= {rx_sync_p1, rx_shift[DATA_BITS-1:1]};
        if (rx_par_en)   rx_par   <= rx_sync_p1;
    end
endmodule

// File: tb/tb_uart_fifo.sv
// Directed bench for uart_fifo: loopback timing, FIFO fill/overrun, parity,
// glitch/break handling and asynchronous reset mid-frame.

module tb_uart_fifo;
    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // DUT A: no parity, optional loopback
    logic       loop_en = 1'b0;
    logic       ser_a   = 1'b1;
    logic       ser_b   = 1'b1;
    logic       rx_line_a, tx_line_a, tx_line_b;
    logic       tx_valid_a = 1'b0, tx_ready_a, rx_valid_a, rx_ready_a = 1'b0;
    logic [7:0] tx_data_a = 8'h00, rx_data_a;
    logic [4:0] tx_level_a, rx_level_a;
    logic       perr_a, ferr_a, ovr_a;
    // DUT B: even parity, driven directly
    logic       tx_ready_b, rx_valid_b, rx_ready_b = 1'b0;
    logic [7:0] rx_data_b;
    logic [4:0] tx_level_b, rx_level_b;
    logic       perr_b, ferr_b, ovr_b;

    int perr_cnt_a = 0, ferr_cnt_a = 0, ovr_cnt_a = 0;
    int perr_cnt_b = 0, ferr_cnt_b = 0;

    assign rx_line_a = loop_en ? tx_line_a : ser_a;

    uart_fifo #(.CLK_HZ(100_000_000), .BAUD(2_000_000), .DATA_BITS(8), .PARITY(0),
                .TX_DEPTH(16), .RX_DEPTH(16)) dut (
        .clock(clock), .reset_n(reset_n), .UART_RX(rx_line_a), .UART_TX(tx_line_a),
        .tx_valid(tx_valid_a), .tx_data(tx_data_a), .tx_ready(tx_ready_a),
        .rx_valid(rx_valid_a), .rx_data(rx_data_a), .rx_ready(rx_ready_a),
        .tx_level(tx_level_a), .rx_level(rx_level_a),
        .rx_parity_err(perr_a), .rx_frame_err(ferr_a), .rx_overrun(ovr_a)
    );

    uart_fifo #(.CLK_HZ(100_000_000), .BAUD(2_000_000), .DATA_BITS(8), .PARITY(2),
                .TX_DEPTH(16), .RX_DEPTH(16)) dut_p (
        .clock(clock), .reset_n(reset_n), .UART_RX(ser_b), .UART_TX(tx_line_b),
        .tx_valid(1'b0), .tx_data(8'h00), .tx_ready(tx_ready_b),
        .rx_valid(rx_valid_b), .rx_data(rx_data_b), .rx_ready(rx_ready_b),
        .tx_level(tx_level_b), .rx_level(rx_level_b),
        .rx_parity_err(perr_b), .rx_frame_err(ferr_b), .rx_overrun(ovr_b)
    );

    // Cycle counter and pulse counters (each counts cycles the pulse is high).
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (perr_a) perr_cnt_a <= perr_cnt_a + 1;
        if (ferr_a) ferr_cnt_a <= ferr_cnt_a + 1;
        if (ovr_a)  ovr_cnt_a  <= ovr_cnt_a + 1;
        if (perr_b) perr_cnt_b <= perr_cnt_b + 1;
        if (ferr_b) ferr_cnt_b <= ferr_cnt_b + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) step();
    endtask

    task automatic set_line(input int sel, input logic v);
        if (sel == 0) ser_a = v;
        else          ser_b = v;
    endtask

    task automatic send_frame(input int sel, input logic [7:0] d, input bit has_par,
                              input logic par, input logic stop);
        set_line(sel, 1'b0);
        step(50);
        for (int b = 0; b < 8; b++) begin
            set_line(sel, d[b]);
            step(50);
        end
        if (has_par) begin
            set_line(sel, par);
            step(50);
        end
        set_line(sel, stop);
        step(50);
        set_line(sel, 1'b1);
    endtask

    task automatic wait_rx_a(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (rx_valid_a) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic pop_a();
        rx_ready_a = 1'b1;
        step();
        rx_ready_a = 1'b0;
    endtask

    initial begin
        int         t0;
        bit         ok;
        bit         bad;
        int         ferr0, perr0, ovr0, perrb0, ferrb0;
        logic [9:0] frame;
        logic [7:0] t2_data [17];

        // ---- Reset state ----
        #1 reset_n = 1'b0;
        step(3);
        chk("rst_uart_tx", 32'(tx_line_a), 32'd1);
        chk("rst_tx_ready", 32'(tx_ready_a), 32'd1);
        chk("rst_rx_valid", 32'(rx_valid_a), 32'd0);
        chk("rst_tx_level", 32'(tx_level_a), 32'd0);
        chk("rst_rx_level", 32'(rx_level_a), 32'd0);
        chk("rst_err_pulses", 32'({perr_a, ferr_a, ovr_a}), 32'd0);
        reset_n = 1'b1;
        step(2);
        chk("rst_tx_idle_after_release", 32'(tx_line_a), 32'd1);

        // ---- T1: loopback 0x55, 0xA3 ----
        loop_en = 1'b1;
        ferr0 = ferr_cnt_a; perr0 = perr_cnt_a; ovr0 = ovr_cnt_a;
        tx_valid_a = 1'b1; tx_data_a = 8'h55;
        step();
        chk("t1_line_high_after_1st_edge", 32'(tx_line_a), 32'd1);
        chk("t1_level_after_push", 32'(tx_level_a), 32'd1);
        tx_data_a = 8'hA3;
        step();
        tx_valid_a = 1'b0;
        t0 = cyc;
        chk("t1_start_on_2nd_edge", 32'(tx_line_a), 32'd0);
        wait_to(t0 + 49);
        chk("t1_start_last_clock", 32'(tx_line_a), 32'd0);
        wait_to(t0 + 50);
        chk("t1_bit0_first_clock", 32'(tx_line_a), 32'd1);
        frame = {1'b1, 8'h55, 1'b0};
        for (int b = 1; b < 10; b++) begin
            wait_to(t0 + 50 * b + 25);
            chk("t1_frame_bit", 32'(tx_line_a), 32'(frame[b]));
        end
        wait_to(t0 + 499);
        chk("t1_stop_last_clock", 32'(tx_line_a), 32'd1);
        wait_to(t0 + 500);
        chk("t1_next_start_no_gap", 32'(tx_line_a), 32'd0);
        wait_rx_a(1500, ok);
        chk("t1_rx1_timeout", 32'(ok), 32'd1);
        chk("t1_rx1_data", 32'(rx_data_a), 32'h55);
        pop_a();
        wait_rx_a(1500, ok);
        chk("t1_rx2_timeout", 32'(ok), 32'd1);
        chk("t1_rx2_data", 32'(rx_data_a), 32'hA3);
        pop_a();
        step(2);
        chk("t1_rx_level_empty", 32'(rx_level_a), 32'd0);
        chk("t1_no_errors", 32'((ferr_cnt_a - ferr0) + (perr_cnt_a - perr0) + (ovr_cnt_a - ovr0)), 32'd0);
        step(200);

        // ---- T2: fill both FIFOs, 17th frame overruns ----
        for (int i = 0; i < 17; i++) t2_data[i] = 8'(i * 29 + 7);
        ferr0 = ferr_cnt_a; perr0 = perr_cnt_a; ovr0 = ovr_cnt_a;
        rx_ready_a = 1'b0;
        tx_valid_a = 1'b1;
        t0 = 0;
        for (int i = 0; i < 17; i++) begin
            tx_data_a = t2_data[i];
            step();
            if (i == 1) t0 = cyc;
        end
        tx_valid_a = 1'b0;
        chk("t2_tx_level_full", 32'(tx_level_a), 32'd16);
        chk("t2_tx_ready_low", 32'(tx_ready_a), 32'd0);
        wait_to(t0 + 7999);
        chk("t2_frame16_stop", 32'(tx_line_a), 32'd1);
        wait_to(t0 + 8000);
        chk("t2_frame17_start_contig", 32'(tx_line_a), 32'd0);
        chk("t2_tx_level_drained", 32'(tx_level_a), 32'd0);
        wait_to(t0 + 8600);
        chk("t2_rx_level_full", 32'(rx_level_a), 32'd16);
        chk("t2_overrun_once", 32'(ovr_cnt_a - ovr0), 32'd1);
        chk("t2_no_frame_parity_err", 32'((ferr_cnt_a - ferr0) + (perr_cnt_a - perr0)), 32'd0);
        rx_ready_a = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("t2_pop_data", 32'(rx_data_a), 32'(t2_data[i]));
            step();
        end
        rx_ready_a = 1'b0;
        chk("t2_rx_empty_after_pops", 32'(rx_valid_a), 32'd0);

        // ---- T3: even parity on DUT B ----
        perrb0 = perr_cnt_b; ferrb0 = ferr_cnt_b;
        send_frame(1, 8'h01, 1'b1, 1'b0, 1'b1);
        step(10);
        chk("t3_parity_err_one_cycle", 32'(perr_cnt_b - perrb0), 32'd1);
        chk("t3_bad_byte_dropped", 32'(rx_valid_b), 32'd0);
        send_frame(1, 8'h01, 1'b1, 1'b1, 1'b1);
        step(10);
        chk("t3_good_valid", 32'(rx_valid_b), 32'd1);
        chk("t3_good_data", 32'(rx_data_b), 32'h01);
        chk("t3_no_extra_errors", 32'((perr_cnt_b - perrb0) + (ferr_cnt_b - ferrb0)), 32'd1);
        rx_ready_b = 1'b1;
        step();
        rx_ready_b = 1'b0;

        // ---- T4: glitch and break on DUT A ----
        loop_en = 1'b0;
        ferr0 = ferr_cnt_a; perr0 = perr_cnt_a;
        ser_a = 1'b0;
        step(10);
        ser_a = 1'b1;
        step(200);
        chk("t4_glitch_no_byte", 32'(rx_level_a), 32'd0);
        chk("t4_glitch_no_error", 32'((ferr_cnt_a - ferr0) + (perr_cnt_a - perr0)), 32'd0);
        ser_a = 1'b0;
        step(1000);
        chk("t4_break_single_frame_err", 32'(ferr_cnt_a - ferr0), 32'd1);
        chk("t4_break_no_byte", 32'(rx_valid_a), 32'd0);
        ser_a = 1'b1;
        step(100);
        chk("t4_after_break_frame_err", 32'(ferr_cnt_a - ferr0), 32'd1);
        chk("t4_after_break_no_byte", 32'(rx_valid_a), 32'd0);
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
        step(10);
        chk("t4_recover_valid", 32'(rx_valid_a), 32'd1);
        chk("t4_recover_data", 32'(rx_data_a), 32'h3C);
        pop_a();

        // ---- T5: reset during TX data bit 3 ----
        tx_valid_a = 1'b1;
        tx_data_a  = 8'hF7;
        t0 = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 1) t0 = cyc;
        end
        tx_valid_a = 1'b0;
        wait_to(t0 + 225);
        chk("t5_in_bit3_low", 32'(tx_line_a), 32'd0);
        chk("t5_tx_level4", 32'(tx_level_a), 32'd4);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_async_tx_high", 32'(tx_line_a), 32'd1);
        chk("t5_tx_level_cleared", 32'(tx_level_a), 32'd0);
        chk("t5_rx_level_cleared", 32'(rx_level_a), 32'd0);
        chk("t5_tx_ready", 32'(tx_ready_a), 32'd1);
        step(2);
        reset_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 700; i++) begin
            step();
            if (tx_line_a !== 1'b1) bad = 1'b1;
        end
        chk("t5_line_idles_high", 32'(bad), 32'd0);
        chk("t5_tx_level_still_0", 32'(tx_level_a), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
